// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
//
// Purpose:
//   Round-robin arbiter that produces a registered, glitch-free select for a
//   downstream 4:1 mux. A grant is held until the owner signals done, the
//   owner withdraws its request, or the grant has lasted HOLD_MAX cycles.
//   Every grant is followed by one RELEASE cycle and one IDLE cycle, so the
//   select never changes while any grant is asserted.
//
// Parameters:
//   HOLD_MAX  - maximum number of cycles a single grant is held (1..255)
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - asynchronous, active-high reset
//   req[3:0]  - per-channel request, bit i asks for sel = i
//   done      - current owner finished, only looked at while granting
//   sel[1:0]  - registered mux select, changes only on IDLE->GRANT
//   grant[3:0]- registered one-hot grant, zero outside GRANT
//   busy      - registered, high exactly while in GRANT
//   timeout   - registered one-cycle pulse when a grant hit HOLD_MAX
// ---------------------------------------------------------------------------
module mux_sel_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // hold_cnt counts completed grant cycles from 0, so the grant is cut
    // when it reads HOLD_MAX-1 at the end of the HOLD_MAX-th cycle.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] last_q, last_d;

    logic [1:0] winner;
    logic       winner_found;
    logic [1:0] cand;

    // Round-robin search starting just after the previous winner: last+1,
    // last+2, last+3 and finally last itself. The 2-bit add wraps mod 4.
    always_comb begin
        winner       = 2'd0;
        winner_found = 1'b0;
        cand         = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!winner_found && req[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic. grant/busy/timeout default to
    // zero so that only GRANT (and the first RELEASE cycle for timeout)
    // ever drives them high; sel and last hold unless explicitly loaded.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = 4'b0000;
        busy_d     = 1'b0;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;

        unique case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d    = GRANT;
                    sel_d      = winner;
                    grant_d    = 4'b0001 << winner;
                    busy_d     = 1'b1;
                    hold_cnt_d = 8'd0;
                end
            end

            GRANT: begin
                if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                // done beats withdrawal beats the hold limit; only a pure
                // limit expiry produces the timeout pulse.
                if (done) begin
                    state_d = RELEASE;
                end else if (!req[sel_q]) begin
                    state_d = RELEASE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    grant_d = grant_q;
                    busy_d  = 1'b1;
                end
            end

            RELEASE: begin
                last_d  = sel_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous reset. last resets to 3 so that
    // channel 0 is first in line after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= 2'b00;
            grant_q    <= 4'b0000;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= 8'd0;
            last_q     <= 2'd3;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
